hpi_bus_sequencer: RTL and testbench



---
 rtl/hpi_bus_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_hpi_bus_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpi_bus_sequencer.sv
// HPI bus sequencer: turns level-based PIO control bits into one timed
// CY7C67200 HPI cycle (SETUP/STROBE/HOLD). Optional macro: HPI_ERR_COUNT_EN.
module hpi_bus_sequencer #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  from_sw_address,
  input  logic [15:0] from_sw_data_out,
  input  logic        from_sw_cs_n,
  input  logic        from_sw_r_n,
  input  logic        from_sw_w_n,
  output logic [15:0] to_sw_data_in,
  output logic        busy,
  inout  wire  [15:0] OTG_DATA,
  output logic [1:0]  OTG_ADDR,
  output logic        OTG_CS_N,
  output logic        OTG_RD_N,
  output logic        OTG_WR_N,
  output logic        OTG_RST_N
`ifdef HPI_ERR_COUNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;

  logic        cs_n_q, r_n_q, w_n_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic        rd_req, wr_req, req_inactive;

  logic        lat_wr, lat_wr_d;
  logic [1:0]  lat_addr, lat_addr_d;
  logic [15:0] lat_data, lat_data_d;

  logic        active_d, cs_n_d, rd_n_d, wr_n_d, oe_d;
  logic        capture;
  logic        data_oe;
  logic [15:0] data_drv;

  // Single synchronising stage for the software-driven PIO levels.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cs_n_q  <= 1'b1;
      r_n_q   <= 1'b1;
      w_n_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cs_n_q  <= from_sw_cs_n;
      r_n_q   <= from_sw_r_n;
      w_n_q   <= from_sw_w_n;
      addr_q  <= from_sw_address;
      wdata_q <= from_sw_data_out;
    end
  end

  assign rd_req       = ~cs_n_q & ~r_n_q &  w_n_q;
  assign wr_req       = ~cs_n_q & ~w_n_q &  r_n_q;
  assign req_inactive =  cs_n_q | (r_n_q & w_n_q);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    lat_wr_d   = lat_wr;
    lat_addr_d = lat_addr;
    lat_data_d = lat_data;
    capture    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rd_req | wr_req) begin
          state_d    = ST_SETUP;
          cnt_d      = SETUP_LD;
          lat_wr_d   = wr_req;
          lat_addr_d = addr_q;
          lat_data_d = wdata_q;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          capture = ~lat_wr;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        if (req_inactive) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Chip-side levels are decoded from the next state and then registered,
    // so the pins switch exactly on the phase boundary and never glitch.
    active_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    cs_n_d   = ~active_d;
    rd_n_d   = ~((state_d == ST_STROBE) && !lat_wr_d);
    wr_n_d   = ~((state_d == ST_STROBE) &&  lat_wr_d);
    oe_d     = active_d & lat_wr_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      lat_wr   <= lat_wr_d;
      lat_addr <= lat_addr_d;
      lat_data <= lat_data_d;
    end
  end

  // NOTE: the async reset clears the output enable too, so a reset in the
  // middle of a write releases the bus immediately, not at the next edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OTG_CS_N <= 1'b1;
      OTG_RD_N <= 1'b1;
      OTG_WR_N <= 1'b1;
      OTG_ADDR <= '0;
      data_oe  <= 1'b0;
      data_drv <= '0;
      busy     <= 1'b0;
    end else begin
      OTG_CS_N <= cs_n_d;
      OTG_RD_N <= rd_n_d;
      OTG_WR_N <= wr_n_d;
      OTG_ADDR <= active_d ? lat_addr_d : 2'b00;
      data_oe  <= oe_d;
      data_drv <= lat_data_d;
      busy     <= active_d;
    end
  end

  assign OTG_DATA = data_oe ? data_drv : 16'hzzzz;

  // Read data is sampled on the edge that ends STROBE, while RD_N is still low.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      to_sw_data_in <= '0;
    end else if (capture) begin
      to_sw_data_in <= OTG_DATA;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OTG_RST_N <= 1'b0;
    end else begin
      OTG_RST_N <= 1'b1;
    end
  end

`ifdef HPI_ERR_COUNT_EN
  logic       illegal_q, illegal_prev;
  logic [7:0] err_cnt;

  assign illegal_q = ~cs_n_q & ~r_n_q & ~w_n_q;

  // One count per assertion of the illegal combination, saturating at 255.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      illegal_prev <= 1'b0;
      err_cnt      <= '0;
    end else begin
      illegal_prev <= illegal_q;
      if ((state == ST_IDLE) && illegal_q && !illegal_prev && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign err_count = err_cnt;
`endif

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Scoreboard bench for hpi_bus_sequencer: two instances (2/4/2 and 1/1/1
// phase lengths) share the PIO stimulus; per-lane monitors check bus cycles.
module tb_hpi_bus_sequencer;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ILL = 2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] data;
  } txn_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  sw_addr = '0;
  logic [15:0] sw_data = '0;
  logic        sw_cs_n = 1'b1;
  logic        sw_r_n = 1'b1;
  logic        sw_w_n = 1'b1;
  logic [15:0] chip_val = '0;

  wire [15:0] din_o  [2];
  wire        busy_o [2];
  wire [1:0]  addr_o [2];
  wire        cs_n_o [2];
  wire        rd_n_o [2];
  wire        wr_n_o [2];
  wire        rst_n_o[2];
`ifdef HPI_ERR_COUNT_EN
  wire [7:0]  err_o  [2];
`endif

  txn_t       exp_q[2][$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_err = '0;

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned SU = (g == 0) ? 2 : 1;
    localparam int unsigned SB = (g == 0) ? 4 : 1;
    localparam int unsigned HO = (g == 0) ? 2 : 1;

    wire [15:0] bus;
    // Chip model: the CY7C67200 drives the bus only while RD_N is low.
    assign bus = (rd_n_o[g] == 1'b0) ? chip_val : 16'hzzzz;

    hpi_bus_sequencer #(
      .SETUP_CYC (SU),
      .STROBE_CYC(SB),
      .HOLD_CYC  (HO)
    ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .from_sw_address (sw_addr),
      .from_sw_data_out(sw_data),
      .from_sw_cs_n    (sw_cs_n),
      .from_sw_r_n     (sw_r_n),
      .from_sw_w_n     (sw_w_n),
      .to_sw_data_in   (din_o[g]),
      .busy            (busy_o[g]),
      .OTG_DATA        (bus),
      .OTG_ADDR        (addr_o[g]),
      .OTG_CS_N        (cs_n_o[g]),
      .OTG_RD_N        (rd_n_o[g]),
      .OTG_WR_N        (wr_n_o[g]),
      .OTG_RST_N       (rst_n_o[g])
`ifdef HPI_ERR_COUNT_EN
      ,
      .err_count       (err_o[g])
`endif
    );

    txn_t        cur = '0;
    bit          in_cyc = 1'b0;
    int          ph = 0;
    int          len[3] = '{0, 0, 0};
    logic [15:0] exp_din = '0;
    logic        strb, wrong;

    // Monitor: measures each CS_N-low window as setup/strobe/hold lengths.
    always @(negedge Clk) begin
      if (Reset) begin
        in_cyc = 1'b0;
        exp_q[g].delete();
        exp_din = '0;
      end else if (!in_cyc && cs_n_o[g]) begin
        check("idle_busy", 32'(busy_o[g]), 0);
        check("idle_strobes", {30'd0, rd_n_o[g], wr_n_o[g]}, 3);
        check("idle_data_in", 32'(din_o[g]), 32'(exp_din));
      end else if (!cs_n_o[g]) begin
        if (!in_cyc) begin
          if (exp_q[g].size() == 0) begin
            check("unexpected_cycle", 1, 0);
            cur = '0;
          end else begin
            cur = exp_q[g].pop_front();
          end
          in_cyc = 1'b1;
          ph = 0;
          len = '{0, 0, 0};
        end
        check("cyc_busy", 32'(busy_o[g]), 1);
        check("cyc_addr", 32'(addr_o[g]), 32'(cur.addr));
        if (cur.wr) check("wr_bus_data", 32'(bus), 32'(cur.data));
        strb  = cur.wr ? ~wr_n_o[g] : ~rd_n_o[g];
        wrong = cur.wr ? ~rd_n_o[g] : ~wr_n_o[g];
        check("wrong_strobe", 32'(wrong), 0);
        if (ph == 0 && strb) ph = 1;
        else if (ph == 1 && !strb) ph = 2;
        else if (ph == 2 && strb) check("strobe_reentry", 1, 0);
        len[ph]++;
      end else begin
        in_cyc = 1'b0;
        check("setup_len", 32'(len[0]), SU);
        check("strobe_len", 32'(len[1]), SB);
        check("hold_len", 32'(len[2]), HO);
        check("done_busy", 32'(busy_o[g]), 0);
        if (!cur.wr) begin
          check("rd_capture", 32'(din_o[g]), 32'(cur.data));
          exp_din = cur.data;
        end
      end
    end
  end

  task automatic set_req(input int kind, input logic [1:0] a, input logic [15:0] d);
    sw_addr = a;
    sw_data = d;
    sw_cs_n = 1'b0;
    sw_r_n  = !(kind == K_RD || kind == K_ILL);
    sw_w_n  = !(kind == K_WR || kind == K_ILL);
  endtask

  task automatic release_req();
    sw_cs_n = 1'b1;
    sw_r_n  = 1'b1;
    sw_w_n  = 1'b1;
  endtask

  task automatic expect_txn(input int kind, input logic [1:0] a, input logic [15:0] d);
    txn_t t;
    t.wr   = (kind == K_WR);
    t.addr = a;
    t.data = (kind == K_WR) ? d : chip_val;
    if (kind != K_ILL) begin
      for (int l = 0; l < 2; l++) exp_q[l].push_back(t);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    while ((busy_o[0] || busy_o[1]) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 100) check("busy_timeout", 1, 0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic check_err();
`ifdef HPI_ERR_COUNT_EN
    for (int l = 0; l < 2; l++) check("err_count", 32'(err_o[l]), 32'(exp_err));
`endif
  endtask

  // Caller is 1 time unit after a rising edge. PIO address/data are scrambled
  // once the cycle has latched them, to show later changes are ignored.
  task automatic do_req(input int kind, input logic [1:0] a, input logic [15:0] d,
                        input logic [15:0] rd_val, input int hold);
    if (kind == K_RD) chip_val = rd_val;
    expect_txn(kind, a, d);
    set_req(kind, a, d);
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      #1;
      if (i == 1) begin
        sw_addr = 2'($urandom);
        sw_data = 16'($urandom);
      end
    end
    release_req();
    wait_idle();
    if (kind == K_ILL && exp_err != 8'hFF) exp_err++;
    check_err();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int r;

    repeat (3) @(posedge Clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      check("rst_cs_n", 32'(cs_n_o[l]), 1);
      check("rst_rd_n", 32'(rd_n_o[l]), 1);
      check("rst_wr_n", 32'(wr_n_o[l]), 1);
      check("rst_addr", 32'(addr_o[l]), 0);
      check("rst_otg_rst_n", 32'(rst_n_o[l]), 0);
      check("rst_data_in", 32'(din_o[l]), 0);
      check("rst_busy", 32'(busy_o[l]), 0);
    end
    check_err();
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    for (int l = 0; l < 2; l++) check("otg_rst_n_release", 32'(rst_n_o[l]), 1);

    // Directed write with latency check: CS_N falls on the second edge.
    expect_txn(K_WR, 2'd2, 16'hBEEF);
    set_req(K_WR, 2'd2, 16'hBEEF);
    @(posedge Clk);
    @(negedge Clk);
    for (int l = 0; l < 2; l++) check("latency_early", 32'(cs_n_o[l]), 1);
    @(posedge Clk);
    @(negedge Clk);
    for (int l = 0; l < 2; l++) check("latency_on_time", 32'(cs_n_o[l]), 0);
    repeat (18) @(posedge Clk);
    #1;
    release_req();
    wait_idle();

    do_req(K_RD, 2'd0, 16'h0000, 16'h1234, 20);

    // Retrigger: a held request yields one cycle; a 1-clock release re-arms.
    chip_val = 16'hA5A5;
    expect_txn(K_RD, 2'd1, 16'h0);
    set_req(K_RD, 2'd1, 16'h0);
    repeat (40) @(posedge Clk);
    #1;
    release_req();
    @(posedge Clk);
    #1;
    chip_val = 16'h5A5A;
    expect_txn(K_RD, 2'd1, 16'h0);
    set_req(K_RD, 2'd1, 16'h0);
    repeat (40) @(posedge Clk);
    #1;
    release_req();
    wait_idle();

    do_req(K_ILL, 2'd1, 16'h1111, 16'h0, 1);
    do_req(K_ILL, 2'd3, 16'h2222, 16'h0, 12);

    // Reset in the middle of a write strobe on the 2/4/2 lane.
    expect_txn(K_WR, 2'd3, 16'hC0DE);
    set_req(K_WR, 2'd3, 16'hC0DE);
    repeat (4) @(posedge Clk);
    #1;
    check("pre_reset_strobe", 32'(wr_n_o[0]), 0);
    Reset = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n_o[0]), 1);
    check("abort_wr_n", 32'(wr_n_o[0]), 1);
    check("abort_busy", 32'(busy_o[0]), 0);
    check("abort_data_in", 32'(din_o[0]), 0);
    check("abort_otg_rst_n", 32'(rst_n_o[0]), 0);
    exp_err = '0;
    check_err();
    release_req();
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("post_abort_otg_rst_n", 32'(rst_n_o[0]), 1);
    do_req(K_RD, 2'd2, 16'h0, 16'h0F0F, 3);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      kind = (r == 0) ? K_ILL : (r < 5) ? K_RD : K_WR;
      do_req(kind, 2'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(1, 40)));
    end

`ifdef HPI_ERR_COUNT_EN
    for (int n = 0; n < 300; n++) do_req(K_ILL, 2'd0, 16'h0, 16'h0, 1);
    check("err_saturated", 32'(exp_err), 255);
`endif

    repeat (5) @(posedge Clk);
    for (int l = 0; l < 2; l++) check("pending_txn", 32'(exp_q[l].size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
